// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;

    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the instruction currently held by fetch.
module next_pc_calc
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = mips_pkg::XLEN
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] inst_addr,
    input  logic            branch_taken,
    input  logic            jr_valid,
    input  logic [XLEN-1:0] jr_target,
    output logic [XLEN-1:0] next_pc,
    output logic            is_syscall,
    output logic            misaligned
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jump_pc;

    assign opcode  = inst[31:26];
    assign funct   = inst[5:0];
    assign pc4     = inst_addr + XLEN'(4);
    assign br_off  = {{(XLEN-18){inst[15]}}, inst[15:0], 2'b00};
    assign jump_pc = {pc4[XLEN-1:28], inst[25:0], 2'b00};

    assign is_syscall = (opcode == OP_RTYPE) && (funct == FN_SYSCALL);

    always_comb begin
        next_pc = pc4;
        // jr_valid wins even when the opcode field also decodes as J/JAL
        if (jr_valid) begin
            next_pc = jr_target;
        end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            next_pc = jump_pc;
        end else if (((opcode == OP_BEQ) || (opcode == OP_BNE)) && branch_taken) begin
            next_pc = pc4 + br_off;
        end
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word at a time over req/ack
// and presents it to the core until retired.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned     XLEN     = mips_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_b,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_ready,
    input  logic            branch_taken,
    input  logic            jr_valid,
    input  logic [XLEN-1:0] jr_target,
    output logic            halted,
    output logic            fetch_error
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_addr_q, inst_addr_d;
    logic [31:0]     inst_q, inst_d;
    logic            fetch_error_q, fetch_error_d;

    logic [XLEN-1:0] next_pc;
    logic            is_syscall;
    logic            misaligned;

    next_pc_calc #(
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .inst         (inst_q),
        .inst_addr    (inst_addr_q),
        .branch_taken (branch_taken),
        .jr_valid     (jr_valid),
        .jr_target    (jr_target),
        .next_pc      (next_pc),
        .is_syscall   (is_syscall),
        .misaligned   (misaligned)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_addr_d   = inst_addr_q;
        fetch_error_d = fetch_error_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    inst_d      = imem_rdata;
                    inst_addr_d = pc_q;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    // PC is left untouched on either halt cause
                    if (is_syscall) begin
                        state_d = HALT;
                    end else if (misaligned) begin
                        state_d       = HALT;
                        fetch_error_d = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            inst_addr_q   <= '0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_addr_q   <= inst_addr_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == HOLD);
    assign inst        = inst_q;
    assign inst_addr   = inst_addr_q;
    assign halted      = (state_q == HALT);
    assign fetch_error = fetch_error_q;

endmodule
